// File: rtl/timing_controller.sv
`default_nettype none
// ============================================================================
// Module      : timing_controller
// Description : Dwell-time counter for the traffic-light / DDI sync FSM.
//               Decodes current_state into a tick threshold, counts clock
//               ticks spent in that state and raises timing_done when the
//               dwell expires. MAINTENANCE and unused codes never time out.
//               Optional build macro TIMING_DONE_PULSE_EN turns timing_done
//               from a level into a single-cycle pulse per dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module timing_controller #(
  parameter int GREEN_TICKS   = 30,
  parameter int YELLOW_TICKS  = 3,
  parameter int ALL_RED_TICKS = 1,
  parameter int CNT_W         = 6
) (
  input  logic       clk,
  input  logic       rst,            // asynchronous, active-low
  input  logic [3:0] current_state,
  output logic       timing_done
);

  // FSM state encodings shared with the sequencing FSM
  localparam logic [3:0] ST_ALL_RED          = 4'd0;
  localparam logic [3:0] ST_PHASE_1_GREEN    = 4'd1;
  localparam logic [3:0] ST_PHASE_1_YELLOW   = 4'd2;
  localparam logic [3:0] ST_PHASE_2_GREEN    = 4'd3;
  localparam logic [3:0] ST_PHASE_2_YELLOW   = 4'd4;
  localparam logic [3:0] ST_EASTBOUND_GREEN  = 4'd5;
  localparam logic [3:0] ST_EASTBOUND_YELLOW = 4'd6;
  localparam logic [3:0] ST_WESTBOUND_GREEN  = 4'd7;
  localparam logic [3:0] ST_WESTBOUND_YELLOW = 4'd8;
  localparam logic [3:0] ST_MAINTENANCE      = 4'd9;

  localparam logic [CNT_W-1:0] GREEN_THR   = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YELLOW_THR  = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] ALL_RED_THR = CNT_W'(ALL_RED_TICKS);

  logic [CNT_W-1:0] timing_threshold;
  logic [3:0]       state_q;
  logic [CNT_W-1:0] count;
  logic             state_change;
  logic             done_cond;

  // Decode the current state into its dwell threshold (0 = never expires)
  always_comb begin
    timing_threshold = '0;
    case (current_state)
      ST_PHASE_1_GREEN, ST_PHASE_2_GREEN,
      ST_EASTBOUND_GREEN, ST_WESTBOUND_GREEN:     timing_threshold = GREEN_THR;
      ST_PHASE_1_YELLOW, ST_PHASE_2_YELLOW,
      ST_EASTBOUND_YELLOW, ST_WESTBOUND_YELLOW:   timing_threshold = YELLOW_THR;
      ST_ALL_RED:                                 timing_threshold = ALL_RED_THR;
      ST_MAINTENANCE:                             timing_threshold = '0;
      default:                                    timing_threshold = '0;
    endcase
  end

  assign state_change = (current_state != state_q);

  // Comparing against the live input means a state change kills done in the
  // same cycle, before the registers have caught up.
  assign done_cond = !state_change && (timing_threshold != '0) &&
                     (count == timing_threshold);

  // Track the state being timed and count ticks, saturating at the threshold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_ALL_RED;
      count   <= '0;
    end else if (state_change) begin
      state_q <= current_state;
      count   <= '0;
    end else if (count != timing_threshold) begin
      count   <= count + CNT_W'(1);
    end
  end

`ifdef TIMING_DONE_PULSE_EN
  logic armed;

  // Armed on every state change (and out of reset); cleared once the pulse fires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b1;
    end else if (state_change) begin
      armed <= 1'b1;
    end else if (done_cond) begin
      armed <= 1'b0;
    end
  end

  assign timing_done = done_cond && armed;
`else
  assign timing_done = done_cond;
`endif

endmodule
`default_nettype wire

// File: tb/tb_timing_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_timing_controller
// Description : Directed self-checking bench for timing_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timing_controller;

  logic       clk;
  logic       rst;
  logic [3:0] current_state;
  logic       timing_done;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef TIMING_DONE_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  timing_controller dut (
    .clk           (clk),
    .rst           (rst),
    .current_state (current_state),
    .timing_done   (timing_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a new code (different from the registered one) and check a full dwell:
  // done after thr+1 edges, then 'extra' further edges of hold behaviour.
  task automatic dwell(input logic [3:0] code, input int thr, input int extra, input string nm);
    current_state = code;
    #1;
    check_eq({nm, " thr"}, 32'(dut.timing_threshold), 32'(thr));
    check_eq({nm, " done drop"}, 32'(timing_done), 32'd0);
    for (int e = 1; e <= thr + 1; e++) begin
      tick();
      check_eq($sformatf("%s done e%0d", nm, e), 32'(timing_done), (e == thr + 1) ? 32'd1 : 32'd0);
      check_eq($sformatf("%s count e%0d", nm, e), 32'(dut.count), 32'(e - 1));
    end
    for (int e = 0; e < extra; e++) begin
      tick();
      check_eq($sformatf("%s hold %0d", nm, e), 32'(timing_done), PULSE ? 32'd0 : 32'd1);
      check_eq($sformatf("%s sat %0d", nm, e), 32'(dut.count), 32'(thr));
    end
  endtask

  // Apply a threshold-0 code and confirm it never expires
  task automatic no_timeout(input logic [3:0] code, input int n, input string nm);
    current_state = code;
    #1;
    check_eq({nm, " thr"}, 32'(dut.timing_threshold), 32'd0);
    for (int e = 1; e <= n; e++) begin
      tick();
      check_eq($sformatf("%s done e%0d", nm, e), 32'(timing_done), 32'd0);
      check_eq($sformatf("%s count e%0d", nm, e), 32'(dut.count), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    current_state = 4'd0;

    // Reset held with ALL_RED
    repeat (10) tick();
    check_eq("rst done", 32'(timing_done), 32'd0);
    check_eq("rst count", 32'(dut.count), 32'd0);
    check_eq("rst state_q", 32'(dut.state_q), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("allred after rst done", 32'(timing_done), 32'd1);
    tick();
    check_eq("allred after rst hold", 32'(timing_done), PULSE ? 32'd0 : 32'd1);

    // Phase 1/2 sequences
    dwell(4'd1, 30, 2, "p1g");
    dwell(4'd2, 3, 1, "p1y");
    dwell(4'd0, 1, 1, "ar1");
    dwell(4'd3, 30, 0, "p2g");
    dwell(4'd4, 3, 1, "p2y");
    dwell(4'd0, 1, 0, "ar2");
    // Eastbound / westbound sequences
    dwell(4'd5, 30, 1, "ebg");
    dwell(4'd6, 3, 0, "eby");
    dwell(4'd0, 1, 0, "ar3");
    dwell(4'd7, 30, 1, "wbg");
    dwell(4'd8, 3, 2, "wby");
    dwell(4'd0, 1, 0, "ar4");

    // Threshold-0 codes
    no_timeout(4'd9, 60, "maint");
    no_timeout(4'd12, 10, "code12");

    // Change away and back before expiry restarts the count
    current_state = 4'd1;
    repeat (5) tick();
    current_state = 4'd2;
    tick();
    check_eq("bounce yellow count", 32'(dut.count), 32'd0);
    dwell(4'd1, 30, 0, "bounce");

    // Mid-green reset discards the dwell
    current_state = 4'd2;
    tick();
    current_state = 4'd3;
    repeat (15) tick();
    check_eq("midrst pre done", 32'(timing_done), 32'd0);
    check_eq("midrst pre count", 32'(dut.count), 32'd14);
    rst = 1'b0;
    #1;
    check_eq("midrst done", 32'(timing_done), 32'd0);
    check_eq("midrst count", 32'(dut.count), 32'd0);
    check_eq("midrst state_q", 32'(dut.state_q), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    dwell(4'd3, 30, 2, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
